router_pkt_register: RTL and testbench
======================================

# router_pkt_register

Parametrised packet register stage between the router input port and the per-destination FIFOs. It accepts a header, payload and trailing parity byte from the source, and forwards every accepted byte, in order, to the FIFO write path. It absorbs up to `HOLD_DEPTH` bytes while the FIFO is full and checks both parity and the header length field. It also runs its own sequencing FSM, so it needs no external state decode.

## Interface
Parameters:
- `DATA_WIDTH`, 8: byte width of `data_in` and `dout`.
- `ADDR_WIDTH`, 2: header bits `[ADDR_WIDTH-1:0]` hold the destination. The all-ones value is invalid.
- `HOLD_DEPTH`, 2: hold-queue entries used while `fifo_full` is high. Minimum 1.
- `PARITY_MODE`, 0: 0 selects XOR of all bytes; 1 selects sum modulo 2^DATA_WIDTH.

Ports:
- `clock`  in  1  single clock, rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `pkt_valid`  in  1  source byte valid. The falling edge marks the parity byte.
- `data_in`  in  DATA_WIDTH  source byte.
- `fifo_full`  in  1  the selected destination FIFO cannot accept a write this cycle.
- `rst_int_reg`  in  1  synchronous clear of `low_pkt_valid`.
- `busy`  out  1  combinational; the source must hold `data_in`/`pkt_valid` while it is high.
- `dout`  out  DATA_WIDTH  byte to the FIFO, registered.
- `dout_valid`  out  1  FIFO write strobe, registered.
- `low_pkt_valid`  out  1  the parity byte has been accepted.
- `parity_done`  out  1  the packet is fully forwarded and the check results are valid.
- `err`  out  1  parity mismatch.
- `len_err`  out  1  payload count differs from the header length field.

## Operation
- Header fields:
  - address = `data_in[ADDR_WIDTH-1:0]`.
  - length L = `data_in[DATA_WIDTH-1:ADDR_WIDTH]`, giving the payload byte count.
- Accept condition: `busy`=0 and the state allows input. Input is never accepted in DRAIN.
- `busy` = (hold count == HOLD_DEPTH) or (state == DRAIN).
- FSM states:
  - IDLE, on an accepted byte with `pkt_valid`=1:
    - address not all-ones: forward the header, seed the parity accumulator with the header, clear the payload counter, clear `parity_done`/`err`/`len_err`, go to PAYLOAD.
    - address all-ones: drop the byte with no output and stay in IDLE.
    - `pkt_valid`=0 in IDLE: ignored.
  - PAYLOAD, on an accepted byte:
    - `pkt_valid`=1: forward it, update the accumulator, increment the counter (saturates at all-ones).
    - `pkt_valid`=0: the byte is the packet parity. Capture it, forward it (it is not added to the accumulator), set `low_pkt_valid`, go to DRAIN.
  - DRAIN: when the hold queue is empty, register `parity_done`=1, `err` = (accumulator != captured parity) and `len_err` = (counter != L), then go to IDLE.
- Forwarding path:
  - `fifo_full`=0 and queue empty: the accepted byte goes straight to `dout` with `dout_valid`=1.
  - `fifo_full`=0 and queue non-empty: the queue head goes to `dout` with `dout_valid`=1. Any accepted byte is pushed the same edge (push and pop together).
  - `fifo_full`=1: the accepted byte is pushed into the queue and `dout_valid`=0.
  - Queue order is strict FIFO. Bytes are never dropped or reordered.
- `low_pkt_valid` is cleared by `rst_int_reg` (priority over set) and by acceptance of a new valid header.
- `parity_done`, `err` and `len_err` hold until the next valid header is accepted.

## Timing
- Reset (asynchronous): state IDLE, queue empty, accumulator/counter/captured parity 0, `dout`=0. Every output reads 0 (`busy`=0). Reset mid-packet discards the packet and the queued bytes.
- Latency: a byte accepted at edge N with `fifo_full`=0 and the queue empty appears on `dout`/`dout_valid` after edge N.
- `dout_valid` is a one-cycle strobe per byte. `dout` holds its last value when `dout_valid`=0.
- Parity byte accepted at edge N, no stall:
  - `low_pkt_valid`=1 after N.
  - DRAIN evaluates at N+1, so `parity_done`/`err`/`len_err` are valid after N+1.
  - The next header can be accepted at N+2.
- Queue full:
  - `busy` rises in the cycle after the edge that filled the queue.
  - The first edge with `fifo_full`=0 pops one entry. `busy` falls after it unless a byte was also pushed.
- Width: the counter is DATA_WIDTH-ADDR_WIDTH bits wide. PARITY_MODE 1 arithmetic wraps modulo 2^DATA_WIDTH.

## Test plan
All scenarios use the default parameters unless stated.
- Nominal XOR: header 0x0D, payload 0x11, 0x22, 0x33, parity 0x0D, `fifo_full`=0 → `dout` sequence 0D, 11, 22, 33, 0D on consecutive cycles; `parity_done`=1, `err`=0, `len_err`=0.
- Parity error: same packet with parity 0x0E → all five bytes forwarded; `err`=1, `len_err`=0, `parity_done`=1.
- Length error: header 0x0D, payload 0x11, 0x22, parity 0x3E → `err`=0, `len_err`=1.
- Invalid address: header 0x0F then a valid 0x0D packet → no output for 0x0F; the 0x0D packet is forwarded normally.
- Backpressure: `fifo_full`=1 for 3 cycles starting at payload 0x11 → 0x11 and 0x22 are queued, `busy`=1, and 0x33 is held by the source. On release the output is 11, 22, 33, parity in order; `parity_done` is asserted only after the queue is empty.
- PARITY_MODE=1: header 0x0D, payload 0x11, 0x22, 0x33, parity 0x73 → `err`=0. Assert `resetn` low mid-payload in a repeat run → all outputs 0 immediately and `busy`=0.

Source files
------------

// File: rtl/router_pkt_register.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : router_pkt_register                                             |
// | Purpose  : packet register stage with hold queue, parity and length check  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module router_pkt_register #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 2,
  parameter int HOLD_DEPTH  = 2,
  parameter int PARITY_MODE = 0
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  rst_int_reg,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  low_pkt_valid,
  output logic                  parity_done,
  output logic                  err,
  output logic                  len_err
);

  localparam int c_LEN_W = DATA_WIDTH - ADDR_WIDTH;
  localparam int c_CNT_W = $clog2(HOLD_DEPTH + 1);
  localparam int c_IDX_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(HOLD_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [DATA_WIDTH-1:0]   r_q [HOLD_DEPTH];
  logic [c_CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0]   r_acc;
  logic [DATA_WIDTH-1:0]   r_par;
  logic [c_LEN_W-1:0]      r_pay_cnt;
  logic [c_LEN_W-1:0]      r_len;

  logic                    w_q_empty;
  logic                    w_addr_ok;
  logic                    w_hdr;
  logic                    w_pay;
  logic                    w_par;
  logic                    w_fwd;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_done;
  logic [c_IDX_W-1:0]      w_wr_idx;
  logic [DATA_WIDTH-1:0]   w_acc_next;

  assign w_q_empty = (r_cnt == '0);
  assign busy      = (r_cnt == c_CNT_FULL) || (r_state == S_DRAIN);
  assign w_addr_ok = (data_in[ADDR_WIDTH-1:0] != '1);

  // busy already covers DRAIN, so !busy is the full accept condition
  assign w_hdr  = !busy && (r_state == S_IDLE) && pkt_valid && w_addr_ok;
  assign w_pay  = !busy && (r_state == S_PAYLOAD) && pkt_valid;
  assign w_par  = !busy && (r_state == S_PAYLOAD) && !pkt_valid;
  assign w_fwd  = w_hdr || w_pay || w_par;
  assign w_pop  = !fifo_full && !w_q_empty;
  assign w_push = w_fwd && (fifo_full || !w_q_empty);
  assign w_done = (r_state == S_DRAIN) && w_q_empty;

  assign w_wr_idx = c_IDX_W'(w_pop ? (r_cnt - c_CNT_ONE) : r_cnt);

  generate
    if (PARITY_MODE == 1) begin : g_sum
      assign w_acc_next = r_acc + data_in;
    end else begin : g_xor
      assign w_acc_next = r_acc ^ data_in;
    end
  endgenerate

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_hdr)     w_next = S_PAYLOAD;
      S_PAYLOAD: if (w_par)     w_next = S_DRAIN;
      S_DRAIN:   if (w_q_empty) w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  // hold queue: entry 0 is the head, a pop shifts everything down one slot
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
      for (int i = 0; i < HOLD_DEPTH; i++) r_q[i] <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < HOLD_DEPTH - 1; i++) r_q[i] <= r_q[i+1];
      end
      if (w_push) r_q[w_wr_idx] <= data_in;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
        2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      dout          <= '0;
      dout_valid    <= 1'b0;
      r_acc         <= '0;
      r_par         <= '0;
      r_pay_cnt     <= '0;
      r_len         <= '0;
      low_pkt_valid <= 1'b0;
      parity_done   <= 1'b0;
      err           <= 1'b0;
      len_err       <= 1'b0;
    end else begin
      r_state    <= w_next;
      dout_valid <= w_pop || (w_fwd && !fifo_full);
      if (w_pop)                      dout <= r_q[0];
      else if (w_fwd && !fifo_full)   dout <= data_in;

      if (w_hdr) begin
        r_acc       <= data_in;
        r_pay_cnt   <= '0;
        r_len       <= data_in[DATA_WIDTH-1:ADDR_WIDTH];
        parity_done <= 1'b0;
        err         <= 1'b0;
        len_err     <= 1'b0;
      end
      if (w_pay) begin
        r_acc <= w_acc_next;
        if (r_pay_cnt != '1) r_pay_cnt <= r_pay_cnt + c_LEN_W'(1);
      end
      if (w_par) r_par <= data_in;

      if (rst_int_reg)  low_pkt_valid <= 1'b0;
      else if (w_par)   low_pkt_valid <= 1'b1;
      else if (w_hdr)   low_pkt_valid <= 1'b0;

      if (w_done) begin
        parity_done <= 1'b1;
        err         <= (r_acc != r_par);
        len_err     <= (r_pay_cnt != r_len);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_register.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_router_pkt_register                                          |
// | Purpose  : bench for router_pkt_register in XOR and SUM parity modes        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_router_pkt_register;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_valid = 1'b0;
  logic       fifo_full;
  logic       rst_int_reg = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic       busy_x, dv_x, lpv_x, pd_x, err_x, lerr_x;
  logic       busy_s, dv_s, lpv_s, pd_s, err_s, lerr_s;
  logic [7:0] dout_x, dout_s;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];
  bit         ff_mode = 1'b0;
  bit         ff_force = 1'b0;
  bit         in_pkt = 1'b0;
  logic       last_ff = 1'b0;
  logic       pd_prev = 1'b0;

  always #5 clock = ~clock;

  router_pkt_register #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .HOLD_DEPTH(2), .PARITY_MODE(0)) u_xor (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .busy(busy_x), .dout(dout_x),
    .dout_valid(dv_x), .low_pkt_valid(lpv_x), .parity_done(pd_x), .err(err_x), .len_err(lerr_x));

  router_pkt_register #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .HOLD_DEPTH(2), .PARITY_MODE(1)) u_sum (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .busy(busy_s), .dout(dout_s),
    .dout_valid(dv_s), .low_pkt_valid(lpv_s), .parity_done(pd_s), .err(err_s), .len_err(lerr_s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_x"}, {busy_x, dv_x, lpv_x, pd_x, err_x, lerr_x, dout_x}, 32'h0);
    chk({tag, "_s"}, {busy_s, dv_s, lpv_s, pd_s, err_s, lerr_s, dout_s}, 32'h0);
  endtask

  always @(negedge clock) fifo_full = ff_mode ? ($urandom_range(0, 2) == 0) : ff_force;
  always @(posedge clock) last_ff <= fifo_full;

  // output scoreboard: every forwarded byte must appear exactly once, in order
  always @(negedge clock) begin
    if (resetn) begin
      if (last_ff) chk("stall_dv", {dv_x, dv_s}, 32'h0);
      if (dv_x || dv_s) begin
        if (exp_q.size() == 0) chk("extra_byte", {dv_x, dv_s}, 32'h0);
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("dout_x", {dv_x, dout_x}, {1'b1, e});
          chk("dout_s", {dv_s, dout_s}, {1'b1, e});
        end
      end
      if (pd_x && !pd_prev) chk("done_before_drained", exp_q.size(), 32'h0);
    end
    pd_prev <= pd_x;
  end

  task automatic send(input logic v, input logic [7:0] d, input bit lat);
    bit fwd;
    pkt_valid = v;
    data_in   = d;
    for (int n = 0; n < 200 && busy_x; n++) tick();
    if (busy_x) chk("busy_timeout", busy_x, 32'h0);
    if (!in_pkt) begin
      fwd    = v && (d[1:0] != 2'b11);
      in_pkt = fwd;
    end else begin
      fwd = 1'b1;
      if (!v) in_pkt = 1'b0;
    end
    tick();
    if (fwd) exp_q.push_back(d);
    if (lat) begin
      chk("lat_dv", {dv_x, dv_s}, {30'h0, fwd, fwd});
      if (fwd) chk("lat_dout", {dout_x, dout_s}, {d, d});
    end
  endtask

  task automatic check_res(input logic [7:0] hdr, input logic [7:0] x, input logic [7:0] s,
                           input logic [7:0] par, input int n);
    int w;
    for (w = 0; w < 200 && !pd_x; w++) tick();
    chk("done", {pd_x, pd_s}, 32'h3);
    chk("err_x", err_x, {31'h0, x != par});
    chk("err_s", err_s, {31'h0, s != par});
    chk("len_err", {lerr_x, lerr_s}, {30'h0, {2{n != int'(hdr[7:2])}}});
  endtask

  // psel 0: correct XOR parity, 1: correct SUM parity, otherwise use par_c
  task automatic run_pkt(input logic [7:0] hdr, input int psel, input logic [7:0] par_c, input bit lat);
    logic [7:0] x, s, par;
    x = hdr;
    s = hdr;
    foreach (pay_q[i]) begin
      x = x ^ pay_q[i];
      s = s + pay_q[i];
    end
    par = (psel == 0) ? x : (psel == 1) ? s : par_c;
    send(1'b1, hdr, lat);
    chk("hdr_clr", {lpv_x, pd_x, err_x, lerr_x, lpv_s, pd_s, err_s, lerr_s}, 32'h0);
    foreach (pay_q[i]) send(1'b1, pay_q[i], lat);
    send(1'b0, par, lat);
    chk("low_set", {lpv_x, lpv_s}, 32'h3);
    if (lat) begin
      chk("drain_busy", {busy_x, pd_x}, 32'h2);
      tick();
      chk("done_lat", {pd_x, pd_s}, 32'h3);
    end
    check_res(hdr, x, s, par, pay_q.size());
    if (lat) chk("idle_busy", busy_x, 32'h0);
  endtask

  initial begin
    logic [7:0] hdr;
    int         len, n;

    repeat (2) @(posedge clock);
    #1 zero_chk("reset");
    @(negedge clock) resetn = 1'b1;
    tick();
    zero_chk("post_reset");

    // nominal packet, then hold / clear of low_pkt_valid
    pay_q = '{8'h11, 8'h22, 8'h33};
    run_pkt(8'h0D, 2, 8'h0D, 1'b1);
    rst_int_reg = 1'b1;
    tick();
    rst_int_reg = 1'b0;
    chk("rst_int", {lpv_x, lpv_s, pd_x, pd_s}, 32'h3);

    run_pkt(8'h0D, 2, 8'h0E, 1'b1);
    pay_q = '{8'h11, 8'h22};
    run_pkt(8'h0D, 2, 8'h3E, 1'b1);

    send(1'b1, 8'h0F, 1'b1);
    pay_q = '{8'h11, 8'h22, 8'h33};
    run_pkt(8'h0D, 2, 8'h0D, 1'b1);
    run_pkt(8'h0D, 2, 8'h73, 1'b1);

    // backpressure across a full hold queue
    send(1'b1, 8'h0D, 1'b1);
    ff_force = 1'b1;
    send(1'b1, 8'h11, 1'b0);
    chk("bp_first", {dv_x, busy_x}, 32'h0);
    send(1'b1, 8'h22, 1'b0);
    chk("bp_full", {dv_x, busy_x}, 32'h1);
    pkt_valid = 1'b1;
    data_in   = 8'h33;
    tick();
    chk("bp_hold", {dv_x, busy_x}, 32'h1);
    ff_force = 1'b0;
    send(1'b1, 8'h33, 1'b0);
    send(1'b0, 8'h0D, 1'b0);
    check_res(8'h0D, 8'h0D, 8'h73, 8'h0D, 3);

    // asynchronous reset mid-payload with bytes queued
    ff_force = 1'b1;
    send(1'b1, 8'h0D, 1'b0);
    send(1'b1, 8'h11, 1'b0);
    #2 resetn = 1'b0;
    #1 zero_chk("async_rst");
    exp_q.delete();
    in_pkt    = 1'b0;
    pkt_valid = 1'b0;
    ff_force  = 1'b0;
    @(negedge clock) resetn = 1'b1;
    tick();
    zero_chk("after_rst");
    run_pkt(8'h0D, 1, 8'h00, 1'b1);

    // randomized packets under random backpressure
    ff_mode = 1'b1;
    for (int k = 0; k < 30; k++) begin
      len = $urandom_range(0, 6);
      n   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : len;
      if ($urandom_range(0, 4) == 0) send(1'b1, {6'($urandom), 2'b11}, 1'b0);
      pay_q.delete();
      for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
      hdr = {6'(len), 2'($urandom_range(0, 2))};
      run_pkt(hdr, $urandom_range(0, 2), 8'($urandom), 1'b0);
    end
    ff_mode = 1'b0;
    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
